alu_ctrl_seq: RTL and testbench
===============================

Name: alu_ctrl_seq

Overview:
Parametrised successor to the combinational ALU decoder for the pipelined RV32IM core. Decodes op5/funct3/funct7 bits/ALUOp into a 5-bit ALU control code and load/store data type, registers the result in a valid/ready pipeline slot, and sequences multi-cycle M-extension operations with an internal cycle counter. Sits between the main control unit (decode stage) and the execute stage.

Parameters:
CTRL_W, 5, width of alu_control.
MUL_CYCLES, 4, execute cycles for MUL/MULH/MULHSU/MULHU (>=1).
DIV_CYCLES, 32, execute cycles for DIV/DIVU/REM/REMU (>=1).
CNT_W, 6, counter width; must satisfy 2^CNT_W > max(MUL_CYCLES, DIV_CYCLES).

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
flush  in  1  discard held/in-flight op
in_valid  in  1  decode-stage request
in_ready  out  1  slot can accept
op5  in  1  instruction bit 5 (1 = R-type/store)
funct3  in  3  instruction funct3
funct7_5  in  1  funct7[5]
funct7_0  in  1  funct7[0] (M-extension select)
alu_op  in  2  00 ld/st, 01 branch, 10 arith, 11 reserved
out_valid  out  1  registered control valid
out_ready  in  1  execute stage accepts
alu_control  out  CTRL_W  ALU operation code
data_type  out  2  00 word, 01 byte, 10 half
load_unsigned  out  1  funct3[2] for loads
illegal  out  1  unsupported encoding
mdu_start  out  1  one-cycle pulse starting multiply/divide unit
mdu_busy  out  1  M-op counting in progress

Behaviour:
- Reset: state EMPTY; out_valid, mdu_start, mdu_busy, illegal, load_unsigned = 0; alu_control = ADD (00000); data_type = 00; counter = 0.
- Codes: ADD 00000, SUB 00001, AND 00010, OR 00011, SLL 00100, SLT 00101, SRL 00110, SRA 00111, BGE 01000, XOR 01001, SLTU 01010, BNE 01011, BLT 01100, BLTU 01101, BGEU 01110, MUL 10000, MULH 10001, MULHSU 10010, MULHU 10011, DIV 10100, DIVU 10101, REM 10110, REMU 10111.
- alu_op 00: ADD; funct3[1:0] 00 byte, 01 half, 10 word, 11 illegal. alu_op 01: beq->SUB, bne/blt/bge/bltu/bgeu per codes; 010/011 illegal. alu_op 10: SUB only when op5=1 and funct7_5=1 and funct3=000; SRA when funct3=101 and funct7_5=1; op5=1 and funct7_0=1 selects M codes by funct3. alu_op 11 or undefined: ADD with illegal=1.
- States: EMPTY, HOLD, MD_RUN.
- in_ready = !flush && (EMPTY or (HOLD and out_ready)). Accept = in_valid && in_ready.
- Single-cycle op accepted at T: outputs registered, out_valid=1 at T+1 (state HOLD). HOLD persists with stable outputs until out_ready; back-to-back accept keeps HOLD.
- M-op accepted at T: state MD_RUN at T+1, mdu_start=1 at T+1 only, mdu_busy=1, counter loaded with N-1 (N = MUL_CYCLES or DIV_CYCLES), decremented each cycle; at counter=0 transition to HOLD, out_valid=1 at T+1+N. alu_control valid throughout MD_RUN.
- flush: next state EMPTY, out_valid/mdu_busy cleared, counter=0; overrides simultaneous accept and counter expiry.
- rst mid-MD_RUN: returns to reset values next edge; no mdu_start issued.
- Illegal ops are single-cycle, reported with out_valid.

Optional Feature:
ALU_MEXT_EN. Defined: M-extension decode, MD_RUN state, counter, mdu_start/mdu_busy as above. Undefined: funct7_0=1 R-type arithmetic decodes as illegal (ADD), no MD_RUN/counter, mdu_start and mdu_busy tied 0; MUL_CYCLES/DIV_CYCLES unused.

Decomposition:
- Package alu_pkg: alu_ctrl_e enum (codes above), data_type_e, alu_op_e, state_e, DT_WORD/DT_BYTE/DT_HALF constants.
- Sub-module alu_decode_comb: pure combinational decode (inputs -> code, data_type, load_unsigned, illegal, is_mul, is_div); alu_ctrl_seq adds register slot, FSM and counter.

Test Plan:
- Reset, then alu_op=10, op5=1, funct3=000, funct7_5=1, out_ready=1 -> next cycle out_valid=1, alu_control=00001; same with op5=0 -> 00000 (addi).
- alu_op=00, funct3=100 / 101 / 010 -> data_type 01/10/00, load_unsigned 1/1/0; funct3=011 -> illegal=1.
- DIV (op5=1, funct7_0=1, funct3=100) at T with DIV_CYCLES=32 -> mdu_start only at T+1, in_ready=0 T+1..T+32, out_valid at T+33, alu_control=10100.
- out_ready=0 for 3 cycles with SRA held -> alu_control=00111 stable, in_ready=0; then out_ready=1 and new in_valid -> accepted same cycle.
- flush at T+5 of MUL run -> out_valid never asserts, state EMPTY, in_ready=1 at T+6; flush with in_valid same cycle -> not accepted.
- Build without ALU_MEXT_EN: MUL encoding -> illegal=1, ADD, out_valid after 1 cycle, mdu_start=0.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared types for the ALU control decoder and its sequencer.
//   alu_ctrl_e  - 5-bit ALU operation codes (M-extension codes have bit 4 set)
//   data_type_e - load/store access width (DT_WORD / DT_BYTE / DT_HALF)
//   alu_op_e    - ALUOp field from the main control unit
//   state_e     - pipeline slot states used by alu_ctrl_seq
package alu_pkg;

    typedef enum logic [4:0] {
        ALU_ADD    = 5'b00000,
        ALU_SUB    = 5'b00001,
        ALU_AND    = 5'b00010,
        ALU_OR     = 5'b00011,
        ALU_SLL    = 5'b00100,
        ALU_SLT    = 5'b00101,
        ALU_SRL    = 5'b00110,
        ALU_SRA    = 5'b00111,
        ALU_BGE    = 5'b01000,
        ALU_XOR    = 5'b01001,
        ALU_SLTU   = 5'b01010,
        ALU_BNE    = 5'b01011,
        ALU_BLT    = 5'b01100,
        ALU_BLTU   = 5'b01101,
        ALU_BGEU   = 5'b01110,
        ALU_MUL    = 5'b10000,
        ALU_MULH   = 5'b10001,
        ALU_MULHSU = 5'b10010,
        ALU_MULHU  = 5'b10011,
        ALU_DIV    = 5'b10100,
        ALU_DIVU   = 5'b10101,
        ALU_REM    = 5'b10110,
        ALU_REMU   = 5'b10111
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        DT_WORD = 2'b00,
        DT_BYTE = 2'b01,
        DT_HALF = 2'b10
    } data_type_e;

    typedef enum logic [1:0] {
        OP_LDST   = 2'b00,
        OP_BRANCH = 2'b01,
        OP_ARITH  = 2'b10,
        OP_RSVD   = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_EMPTY  = 2'b00,
        ST_HOLD   = 2'b01,
        ST_MD_RUN = 2'b10
    } state_e;

endpackage

// File: rtl/alu_decode_comb.sv
// alu_decode_comb: purely combinational ALU control decode.
// Inputs : op5, funct3, funct7_5, funct7_0, alu_op (instruction/control fields)
// Outputs: code (ALU op), data_type, load_unsigned, illegal;
//          is_mul / is_div only exist when ALU_MEXT_EN is defined.
// Build option ALU_MEXT_EN: when undefined, R-type encodings with funct7_0=1
// decode as illegal (ADD).
module alu_decode_comb
    import alu_pkg::*;
(
    input  logic       op5,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       funct7_0,
    input  logic [1:0] alu_op,
    output alu_ctrl_e  code,
    output data_type_e data_type,
    output logic       load_unsigned,
    output logic       illegal
`ifdef ALU_MEXT_EN
    ,
    output logic       is_mul,
    output logic       is_div
`endif
);

    always_comb begin
        code          = ALU_ADD;
        data_type     = DT_WORD;
        load_unsigned = 1'b0;
        illegal       = 1'b0;
`ifdef ALU_MEXT_EN
        is_mul        = 1'b0;
        is_div        = 1'b0;
`endif
        case (alu_op_e'(alu_op))
            OP_LDST: begin
                load_unsigned = funct3[2];
                case (funct3[1:0])
                    2'b00:   data_type = DT_BYTE;
                    2'b01:   data_type = DT_HALF;
                    2'b10:   data_type = DT_WORD;
                    default: illegal   = 1'b1;
                endcase
            end
            OP_BRANCH: begin
                case (funct3)
                    3'b000:  code = ALU_SUB;
                    3'b001:  code = ALU_BNE;
                    3'b100:  code = ALU_BLT;
                    3'b101:  code = ALU_BGE;
                    3'b110:  code = ALU_BLTU;
                    3'b111:  code = ALU_BGEU;
                    default: illegal = 1'b1;
                endcase
            end
            OP_ARITH: begin
                if (op5 && funct7_0) begin
`ifdef ALU_MEXT_EN
                    // M codes are 10 followed by funct3; funct3[2] splits mul/div
                    code   = alu_ctrl_e'({2'b10, funct3});
                    is_mul = !funct3[2];
                    is_div = funct3[2];
`else
                    illegal = 1'b1;
`endif
                end else begin
                    case (funct3)
                        3'b000:  code = (op5 && funct7_5) ? ALU_SUB : ALU_ADD;
                        3'b001:  code = ALU_SLL;
                        3'b010:  code = ALU_SLT;
                        3'b011:  code = ALU_SLTU;
                        3'b100:  code = ALU_XOR;
                        // srai carries funct7_5 in the immediate, so op5 is not required
                        3'b101:  code = funct7_5 ? ALU_SRA : ALU_SRL;
                        3'b110:  code = ALU_OR;
                        default: code = ALU_AND;
                    endcase
                end
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_ctrl_seq.sv
// alu_ctrl_seq: ALU control decode registered into a valid/ready slot, with
// multi-cycle sequencing of M-extension operations.
// Ports: clk, rst (sync, active-high), flush; in_valid/in_ready from decode;
//        op5, funct3, funct7_5, funct7_0, alu_op; out_valid/out_ready to
//        execute; alu_control, data_type, load_unsigned, illegal (registered);
//        mdu_start (1-cycle pulse), mdu_busy.
// Build option ALU_MEXT_EN: enables M decode, MD_RUN state and the cycle
// counter. Undefined: mdu_start/mdu_busy are tied low and the cycle-count
// parameters do not exist.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_EMPTY  | slot empty, accepting
// ST_HOLD   | result valid, held until out_ready
// ST_MD_RUN | multiply/divide counting down, result not yet valid
module alu_ctrl_seq
    import alu_pkg::*;
#(
    parameter int CTRL_W     = 5
`ifdef ALU_MEXT_EN
    ,
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32,
    parameter int CNT_W      = 6
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              op5,
    input  logic [2:0]        funct3,
    input  logic              funct7_5,
    input  logic              funct7_0,
    input  logic [1:0]        alu_op,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] alu_control,
    output logic [1:0]        data_type,
    output logic              load_unsigned,
    output logic              illegal,
    output logic              mdu_start,
    output logic              mdu_busy
);

    state_e     state;
    alu_ctrl_e  dec_code;
    data_type_e dec_dt;
    logic       dec_lu;
    logic       dec_ill;
    logic       accept;

`ifdef ALU_MEXT_EN
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

    logic             dec_is_mul;
    logic             dec_is_div;
    logic [CNT_W-1:0] cnt;
`endif

    alu_decode_comb u_dec (
        .op5          (op5),
        .funct3       (funct3),
        .funct7_5     (funct7_5),
        .funct7_0     (funct7_0),
        .alu_op       (alu_op),
        .code         (dec_code),
        .data_type    (dec_dt),
        .load_unsigned(dec_lu),
        .illegal      (dec_ill)
`ifdef ALU_MEXT_EN
        ,
        .is_mul       (dec_is_mul),
        .is_div       (dec_is_div)
`endif
    );

    assign in_ready = !flush && (state == ST_EMPTY || (state == ST_HOLD && out_ready));
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_EMPTY;
            out_valid     <= 1'b0;
            alu_control   <= '0;
            data_type     <= 2'b00;
            load_unsigned <= 1'b0;
            illegal       <= 1'b0;
`ifdef ALU_MEXT_EN
            mdu_start     <= 1'b0;
            mdu_busy      <= 1'b0;
            cnt           <= '0;
`endif
        end else if (flush) begin
            // flush beats a pending accept (in_ready is already low) and counter expiry
            state     <= ST_EMPTY;
            out_valid <= 1'b0;
`ifdef ALU_MEXT_EN
            mdu_start <= 1'b0;
            mdu_busy  <= 1'b0;
            cnt       <= '0;
`endif
        end else begin
`ifdef ALU_MEXT_EN
            mdu_start <= 1'b0;
`endif
            if (accept) begin
                alu_control   <= CTRL_W'(dec_code);
                data_type     <= dec_dt;
                load_unsigned <= dec_lu;
                illegal       <= dec_ill;
`ifdef ALU_MEXT_EN
                if (dec_is_mul || dec_is_div) begin
                    state     <= ST_MD_RUN;
                    out_valid <= 1'b0;
                    mdu_start <= 1'b1;
                    mdu_busy  <= 1'b1;
                    cnt       <= dec_is_div ? DIV_LOAD : MUL_LOAD;
                end else
`endif
                begin
                    state     <= ST_HOLD;
                    out_valid <= 1'b1;
                end
            end else if (state == ST_HOLD && out_ready) begin
                state     <= ST_EMPTY;
                out_valid <= 1'b0;
            end
`ifdef ALU_MEXT_EN
            else if (state == ST_MD_RUN) begin
                if (cnt == '0) begin
                    state     <= ST_HOLD;
                    out_valid <= 1'b1;
                    mdu_busy  <= 1'b0;
                end else begin
                    cnt <= cnt - CNT_W'(1);
                end
            end
`endif
        end
    end

`ifndef ALU_MEXT_EN
    assign mdu_start = 1'b0;
    assign mdu_busy  = 1'b0;
`endif

endmodule

// File: tb/tb_alu_ctrl_seq.sv
module tb_alu_ctrl_seq;

    localparam int MUL_N = 4;
    localparam int DIV_N = 32;

    // funct3-indexed reference tables
    localparam logic [4:0] BR_TAB [8] = '{5'd1, 5'd11, 5'd0, 5'd0, 5'd12, 5'd8, 5'd13, 5'd14};
    localparam logic [4:0] AR_TAB [8] = '{5'd0, 5'd4, 5'd5, 5'd10, 5'd9, 5'd6, 5'd3, 5'd2};
    localparam logic [1:0] DT_TAB [4] = '{2'd1, 2'd2, 2'd0, 2'd0};

    localparam logic [2:0] LD_F3  [4] = '{3'd4, 3'd5, 3'd2, 3'd3};
    localparam logic [1:0] LD_DT  [4] = '{2'd1, 2'd2, 2'd0, 2'd0};
    localparam logic       LD_LU  [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    localparam logic       LD_ILL [4] = '{1'b0, 1'b0, 1'b0, 1'b1};

    logic       clk = 1'b0;
    logic       rst, flush, in_valid, in_ready, op5, funct7_5, funct7_0;
    logic       out_valid, out_ready, load_unsigned, illegal, mdu_start, mdu_busy;
    logic [2:0] funct3;
    logic [1:0] alu_op, data_type;
    logic [4:0] alu_control;

    always #5 clk = ~clk;

    alu_ctrl_seq dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .op5          (op5),
        .funct3       (funct3),
        .funct7_5     (funct7_5),
        .funct7_0     (funct7_0),
        .alu_op       (alu_op),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .alu_control  (alu_control),
        .data_type    (data_type),
        .load_unsigned(load_unsigned),
        .illegal      (illegal),
        .mdu_start    (mdu_start),
        .mdu_busy     (mdu_busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (timestamp based) ----------------
    int         cyc = 0;
    bit         started = 1'b0;
    bit         m_full = 1'b0;
    int         m_out_at = 0;
    int         m_start_at = -1;
    logic [4:0] e_code = '0;
    logic [1:0] e_dt = '0;
    logic       e_lu = 1'b0;
    logic       e_ill = 1'b0;
    bit         m_acc;
    int         m_n;

    function automatic void ref_decode(input logic [1:0] aop, input logic [2:0] f3,
                                       input logic o5, input logic f75, input logic f70,
                                       output logic [4:0] code, output logic [1:0] dt,
                                       output logic lu, output logic ill, output int md_n);
        code = '0; dt = '0; lu = 1'b0; ill = 1'b0; md_n = 0;
        if (aop == 2'd0) begin
            lu = f3[2];
            if (f3[1:0] == 2'd3) ill = 1'b1;
            else dt = DT_TAB[f3[1:0]];
        end else if (aop == 2'd1) begin
            if (f3 == 3'd2 || f3 == 3'd3) ill = 1'b1;
            else code = BR_TAB[f3];
        end else if (aop == 2'd2) begin
            if (o5 && f70) begin
`ifdef ALU_MEXT_EN
                code = 5'(16 + int'(f3));
                md_n = f3[2] ? DIV_N : MUL_N;
`else
                ill = 1'b1;
`endif
            end else begin
                code = AR_TAB[f3];
                if (f75 && (f3 == 3'd5 || (f3 == 3'd0 && o5))) code = code + 5'd1;
            end
        end else begin
            ill = 1'b1;
        end
    endfunction

    function automatic bit m_ov();
        return m_full && cyc >= m_out_at;
    endfunction

    function automatic bit m_busy();
        return m_full && cyc < m_out_at;
    endfunction

    function automatic bit m_in_ready();
        return !flush && (!m_full || (m_ov() && out_ready));
    endfunction

    always @(posedge clk) begin
        m_acc = in_valid && m_in_ready();
        if (rst) begin
            m_full = 1'b0;
            e_code = '0; e_dt = '0; e_lu = 1'b0; e_ill = 1'b0;
            started = 1'b1;
        end else if (flush) begin
            m_full = 1'b0;
        end else if (m_acc) begin
            ref_decode(alu_op, funct3, op5, funct7_5, funct7_0, e_code, e_dt, e_lu, e_ill, m_n);
            m_full     = 1'b1;
            m_start_at = (m_n > 0) ? cyc + 1 : -1;
            m_out_at   = cyc + 1 + m_n;
        end else if (m_ov() && out_ready) begin
            m_full = 1'b0;
        end
        cyc++;
    end

    always @(negedge clk) begin
        if (started) begin
            chk("in_ready", in_ready, m_in_ready());
            chk("out_valid", out_valid, m_ov());
            chk("mdu_start", mdu_start, m_full && cyc == m_start_at);
            chk("mdu_busy", mdu_busy, m_busy());
            if (m_ov() || m_busy()) begin
                chk("alu_control", alu_control, e_code);
                chk("illegal", illegal, e_ill);
                chk("data_type", data_type, e_dt);
                chk("load_unsigned", load_unsigned, e_lu);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [1:0] aop, input logic [2:0] f3,
                          input logic o5, input logic f75, input logic f70);
        alu_op = aop; funct3 = f3; op5 = o5; funct7_5 = f75; funct7_0 = f70;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        set_op(2'b00, 3'b000, 1'b0, 1'b0, 1'b0);
        step(); step();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_alu_control", alu_control, 0);
        chk("rst_data_type", data_type, 0);
        chk("rst_load_unsigned", load_unsigned, 0);
        chk("rst_illegal", illegal, 0);
        chk("rst_mdu_start", mdu_start, 0);
        chk("rst_mdu_busy", mdu_busy, 0);
        rst = 1'b0;

        // sub, then back-to-back addi
        in_valid = 1'b1;
        set_op(2'b10, 3'b000, 1'b1, 1'b1, 1'b0);
        step();
        chk("sub_valid", out_valid, 1);
        chk("sub_code", alu_control, 5'b00001);
        set_op(2'b10, 3'b000, 1'b0, 1'b1, 1'b0);
        step();
        chk("addi_valid", out_valid, 1);
        chk("addi_code", alu_control, 5'b00000);

        // load widths
        for (int i = 0; i < 4; i++) begin
            set_op(2'b00, LD_F3[i], 1'b0, 1'b0, 1'b0);
            step();
            chk("ld_dt", data_type, LD_DT[i]);
            chk("ld_lu", load_unsigned, LD_LU[i]);
            chk("ld_ill", illegal, LD_ILL[i]);
        end
        in_valid = 1'b0;
        step();

        // DIV
        in_valid = 1'b1;
        set_op(2'b10, 3'b100, 1'b1, 1'b0, 1'b1);
        step();
        in_valid = 1'b0;
`ifdef ALU_MEXT_EN
        chk("div_start", mdu_start, 1);
        chk("div_busy", mdu_busy, 1);
        chk("div_in_ready", in_ready, 0);
        chk("div_code_run", alu_control, 5'b10100);
        n = 1;
        while (!out_valid && n < 60) begin
            step();
            n++;
        end
        chk("div_latency", n, 33);
        chk("div_code", alu_control, 5'b10100);
        chk("div_illegal", illegal, 0);
`else
        chk("mext_off_valid", out_valid, 1);
        chk("mext_off_illegal", illegal, 1);
        chk("mext_off_code", alu_control, 5'b00000);
        chk("mext_off_start", mdu_start, 0);
        chk("mext_off_busy", mdu_busy, 0);
`endif
        step();

        // SRA held under backpressure
        out_ready = 1'b0;
        in_valid  = 1'b1;
        set_op(2'b10, 3'b101, 1'b1, 1'b1, 1'b0);
        step();
        set_op(2'b00, 3'b001, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("sra_hold_code", alu_control, 5'b00111);
            chk("sra_hold_in_ready", in_ready, 0);
            chk("sra_hold_valid", out_valid, 1);
            step();
        end
        out_ready = 1'b1;
        #1;
        chk("sra_release_in_ready", in_ready, 1);
        step();
        chk("after_sra_code", alu_control, 5'b00000);
        chk("after_sra_dt", data_type, 2'b10);
        in_valid = 1'b0;
        step();

`ifdef ALU_MEXT_EN
        // flush mid MUL run
        in_valid = 1'b1;
        set_op(2'b10, 3'b000, 1'b1, 1'b0, 1'b1);
        step();
        in_valid = 1'b0;
        step(); step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        #1;
        chk("flush_mul_valid", out_valid, 0);
        chk("flush_mul_busy", mdu_busy, 0);
        chk("flush_mul_in_ready", in_ready, 1);
        for (int i = 0; i < 6; i++) begin
            step();
            chk("flush_mul_never_valid", out_valid, 0);
        end
`else
        // flush a held op
        out_ready = 1'b0;
        in_valid  = 1'b1;
        set_op(2'b10, 3'b110, 1'b1, 1'b0, 1'b0);
        step();
        in_valid = 1'b0;
        flush    = 1'b1;
        step();
        flush     = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("flush_hold_valid", out_valid, 0);
        chk("flush_hold_in_ready", in_ready, 1);
`endif

        // flush and in_valid together: not accepted
        flush    = 1'b1;
        in_valid = 1'b1;
        set_op(2'b10, 3'b000, 1'b1, 1'b1, 1'b0);
        #1;
        chk("flush_in_ready", in_ready, 0);
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_no_accept", out_valid, 0);
        step();

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst       = ($urandom_range(0, 199) == 0);
            flush     = ($urandom_range(0, 19) == 0);
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 7);
            set_op(2'($urandom), 3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                alu_op = 2'b10; op5 = 1'b1; funct7_0 = 1'b1;
            end
            step();
        end
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 40; i++) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
